// File: rtl/llc_mshr_alloc_if.sv
// llc_mshr_alloc_if: allocation, free and status signals of the MSHR pool allocator
interface llc_mshr_alloc_if #(parameter int MSHR_BITS = 4);
  logic [1:0]           alloc_valid;
  logic [1:0]           alloc_ready;
  logic [MSHR_BITS-1:0] alloc_id;
  logic                 free_valid;
  logic [MSHR_BITS-1:0] free_id;
  logic [MSHR_BITS:0]   mshr_cnt;
  logic                 mshr_full;
  logic                 mshr_idle;
  logic                 err_double_free;
  modport master (
    output alloc_valid, free_valid, free_id,
    input  alloc_ready, alloc_id, mshr_cnt, mshr_full, mshr_idle, err_double_free
  );
  modport slave (
    input  alloc_valid, free_valid, free_id,
    output alloc_ready, alloc_id, mshr_cnt, mshr_full, mshr_idle, err_double_free
  );
endinterface

// File: rtl/llc_mshr_alloc.sv
// llc_mshr_alloc: MSHR free-map owner with round-robin, reserve-aware two-requester allocation
module llc_mshr_alloc #(
  parameter int N_MSHR    = 16,
  parameter int MSHR_BITS = 4,
  parameter int RESERVE   = 1
) (
  input logic              clk,
  input logic              rst,
  llc_mshr_alloc_if.slave  bus
);
  logic [N_MSHR-1:0]    free_map_q, free_map_d;
  logic [MSHR_BITS:0]   mshr_cnt_q, mshr_cnt_d;
  logic                 rr_q, rr_d;
  logic                 err_double_free_q, err_double_free_d;
  logic                 elig0, elig1, req0, req1, commit, legal_free;
  logic [1:0]           ready, grant;
  logic [MSHR_BITS-1:0] low_id;
  always_comb begin
    low_id = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) low_id = free_map_q[i] ? MSHR_BITS'(i) : low_id;
  end
  assign elig1 = mshr_cnt_q != '0;
  assign elig0 = mshr_cnt_q > (MSHR_BITS+1)'(RESERVE);
  assign req0  = bus.alloc_valid[0] & elig0;
  assign req1  = bus.alloc_valid[1] & elig1;
  // A requester's own valid never gates its ready; only the rival's request can take it away
  assign ready[0] = ~rst & elig0 & ~(req1 & rr_q);
  assign ready[1] = ~rst & elig1 & ~(req0 & ~rr_q);
  assign grant    = bus.alloc_valid & ready;
  assign commit   = |grant;
  // Freeing an entry the registered map already shows free (including this cycle's alloc_id) is illegal
  assign legal_free = bus.free_valid && (int'(bus.free_id) < N_MSHR) && !free_map_q[bus.free_id];
  always_comb begin
    free_map_d = free_map_q;
    if (commit) free_map_d[low_id] = 1'b0;
    if (legal_free) free_map_d[bus.free_id] = 1'b1;
    mshr_cnt_d = mshr_cnt_q - (MSHR_BITS+1)'(commit) + (MSHR_BITS+1)'(legal_free);
    rr_d = commit ? ~grant[1] : rr_q;
    err_double_free_d = bus.free_valid & ~legal_free;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_q        <= '1;
      mshr_cnt_q        <= (MSHR_BITS+1)'(N_MSHR);
      rr_q              <= 1'b0;
      err_double_free_q <= 1'b0;
    end else begin
      free_map_q        <= free_map_d;
      mshr_cnt_q        <= mshr_cnt_d;
      rr_q              <= rr_d;
      err_double_free_q <= err_double_free_d;
    end
  end
  assign bus.alloc_ready     = ready;
  assign bus.alloc_id        = low_id;
  assign bus.mshr_cnt        = mshr_cnt_q;
  assign bus.mshr_full       = mshr_cnt_q == '0;
  assign bus.mshr_idle       = mshr_cnt_q == (MSHR_BITS+1)'(N_MSHR);
  assign bus.err_double_free = err_double_free_q;
  a_cnt_popcount: assert property (@(posedge clk) disable iff (rst)
    $countones(free_map_q) == int'(mshr_cnt_q));
endmodule

// File: tb/tb_llc_mshr_alloc.sv
// tb_llc_mshr_alloc: directed stimulus with a free-set reference model and literal spot checks
module tb_llc_mshr_alloc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_n = 0;
  int   total_n = 0;
  llc_mshr_alloc_if #(.MSHR_BITS(2)) bus ();
  llc_mshr_alloc #(.N_MSHR(4), .MSHR_BITS(2), .RESERVE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference model: which entries are free, who has priority, pending error pulse
  int m_free[4];
  int m_rr, m_err, m_cnt, m_low, m_g;
  bit m_e0, m_e1, m_r0, m_r1, m_armed = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", int'(bus.alloc_ready), 0);
      foreach (m_free[i]) m_free[i] = 1;
      m_rr = 0; m_err = 0; m_armed = 1;
    end else if (m_armed) begin
      m_cnt = 0; m_low = -1;
      for (int i = 0; i < 4; i++) begin
        m_cnt += m_free[i];
        if (m_free[i] == 1 && m_low < 0) m_low = i;
      end
      m_e1 = m_cnt > 0;
      m_e0 = m_cnt > 1;
      m_r0 = bus.alloc_valid[0] && m_e0;
      m_r1 = bus.alloc_valid[1] && m_e1;
      m_g  = (m_r0 && m_r1) ? m_rr : m_r0 ? 0 : m_r1 ? 1 : -1;
      chk("cnt", int'(bus.mshr_cnt), m_cnt);
      chk("full", int'(bus.mshr_full), int'(m_cnt == 0));
      chk("idle", int'(bus.mshr_idle), int'(m_cnt == 4));
      chk("err", int'(bus.err_double_free), m_err);
      if (!m_e0 || bus.alloc_valid[0]) chk("ready0", int'(bus.alloc_ready[0]), int'(m_g == 0));
      if (!m_e1 || bus.alloc_valid[1]) chk("ready1", int'(bus.alloc_ready[1]), int'(m_g == 1));
      if (m_g >= 0) chk("alloc_id", int'(bus.alloc_id), m_low);
      m_err = 0;
      if (bus.free_valid) m_err = m_free[bus.free_id];
      if (m_g >= 0) begin
        m_free[m_low] = 0;
        m_rr = 1 - m_g;
      end
      if (bus.free_valid && m_err == 0) m_free[bus.free_id] = 1;
    end
  end

  task automatic set_in(input logic [1:0] v, input logic fv, input logic [1:0] fid);
    bus.alloc_valid = v;
    bus.free_valid  = fv;
    bus.free_id     = fid;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    set_in(2'b00, 1'b0, 2'd0);
    @(negedge clk);
    chk("lit_rst_ready", int'(bus.alloc_ready), 0);
    nxt();
    rst = 1'b0;
  endtask
  // one cycle with given inputs; checks literal ready/id/cnt expectations at mid-cycle
  task automatic cyc(input string name, input logic [1:0] v, input logic fv, input logic [1:0] fid,
                     input int exp_ready, input int exp_id, input int exp_cnt);
    set_in(v, fv, fid);
    @(negedge clk);
    chk({name, "_ready"}, int'(bus.alloc_ready & v), exp_ready);
    if (exp_id >= 0) chk({name, "_id"}, int'(bus.alloc_id), exp_id);
    chk({name, "_cnt"}, int'(bus.mshr_cnt), exp_cnt);
    nxt();
  endtask

  initial begin
    set_in(2'b00, 1'b0, 2'd0);
    nxt();
    do_reset();
    set_in(2'b00, 1'b0, 2'd0);
    @(negedge clk);
    chk("idle_cnt", int'(bus.mshr_cnt), 4);
    chk("idle_idle", int'(bus.mshr_idle), 1);
    chk("idle_full", int'(bus.mshr_full), 0);
    chk("idle_err", int'(bus.err_double_free), 0);
    nxt();
    // requester 0 alone until the reserve blocks it
    cyc("r0_c1", 2'b01, 1'b0, 2'd0, 1, 0, 4);
    cyc("r0_c2", 2'b01, 1'b0, 2'd0, 1, 1, 3);
    cyc("r0_c3", 2'b01, 1'b0, 2'd0, 1, 2, 2);
    cyc("r0_c4", 2'b01, 1'b0, 2'd0, 0, -1, 1);
    // requester 1 takes the reserved entry, then the pool is full
    cyc("r1_res", 2'b10, 1'b0, 2'd0, 2, 3, 1);
    set_in(2'b11, 1'b0, 2'd0);
    @(negedge clk);
    chk("full_flag", int'(bus.mshr_full), 1);
    chk("full_ready", int'(bus.alloc_ready), 0);
    nxt();
    // free from full: entry only allocatable the following cycle
    cyc("ff_free", 2'b10, 1'b1, 2'd2, 0, -1, 0);
    cyc("ff_grant", 2'b10, 1'b0, 2'd0, 2, 2, 1);
    cyc("ff_after", 2'b00, 1'b0, 2'd0, 0, -1, 0);
    // both requesters from reset alternate
    do_reset();
    cyc("alt_1", 2'b11, 1'b0, 2'd0, 1, 0, 4);
    cyc("alt_2", 2'b11, 1'b0, 2'd0, 2, 1, 3);
    cyc("alt_3", 2'b11, 1'b0, 2'd0, 1, 2, 2);
    cyc("alt_4", 2'b11, 1'b0, 2'd0, 2, 3, 1);
    cyc("alt_5", 2'b11, 1'b0, 2'd0, 0, -1, 0);
    // concurrent free and alloc, then a double free
    do_reset();
    cyc("cf_a0", 2'b01, 1'b0, 2'd0, 1, 0, 4);
    cyc("cf_mix", 2'b01, 1'b1, 2'd0, 1, 1, 3);
    cyc("cf_dbl", 2'b00, 1'b1, 2'd0, 0, -1, 3);
    set_in(2'b00, 1'b0, 2'd0);
    @(negedge clk);
    chk("dbl_err_hi", int'(bus.err_double_free), 1);
    chk("dbl_cnt", int'(bus.mshr_cnt), 3);
    nxt();
    @(negedge clk);
    chk("dbl_err_lo", int'(bus.err_double_free), 0);
    nxt();
    // freeing the entry being allocated this very cycle is a double free
    do_reset();
    cyc("same_id", 2'b01, 1'b1, 2'd0, 1, 0, 4);
    set_in(2'b00, 1'b0, 2'd0);
    @(negedge clk);
    chk("same_err", int'(bus.err_double_free), 1);
    chk("same_cnt", int'(bus.mshr_cnt), 3);
    nxt();
    // reset mid-grant drops the allocation
    set_in(2'b10, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    set_in(2'b00, 1'b0, 2'd0);
    @(negedge clk);
    chk("mid_rst_cnt", int'(bus.mshr_cnt), 4);
    nxt();
    repeat (2) nxt();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
